// File: rtl/jk_checker_pkg.sv
// Shared types and the JK next-state function for the JK flip-flop checker.
package jk_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } chk_state_e;

  // jk[1] is J, jk[0] is K.
  function automatic logic jk_next(input logic q, input logic [1:0] jk);
    logic nq;
    unique case (jk_op_e'(jk))
      HOLD:    nq = q;
      CLR:     nq = 1'b0;
      SET:     nq = 1'b1;
      TGL:     nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_checker_if.sv
// Observation and status bundle between a JK flip-flop under test and its checker.
interface jk_checker_if #(
  parameter int CNT_W = 16
) ();
  logic             en;
  logic             clr;
  logic [1:0]       jk;
  logic             q;
  logic             exp_q;
  logic             err_pulse;
  logic             err_sticky;
  logic [CNT_W-1:0] check_cnt;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [1:0]       state;

  modport master (
    output en, clr, jk, q,
    input  exp_q, err_pulse, err_sticky, check_cnt, mismatch_cnt, state
  );

  modport slave (
    input  en, clr, jk, q,
    output exp_q, err_pulse, err_sticky, check_cnt, mismatch_cnt, state
  );
endinterface

// File: rtl/jk_ref_model.sv
// One-bit reference JK flip-flop: load resyncs from the observed q, step advances itself.
module jk_ref_model
  import jk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [1:0] jk_i,
  input  logic       q_i,
  output logic       exp_q_o
);

  logic exp_q_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q_q <= 1'b0;
    end else if (load_i) begin
      exp_q_q <= jk_next(q_i, jk_i);
    end else if (step_i) begin
      exp_q_q <= jk_next(exp_q_q, jk_i);
    end
  end

  assign exp_q_o = exp_q_q;

endmodule

// File: rtl/jk_checker.sv
// Compares an observed JK flip-flop against a reference model, counting checks and mismatches.
module jk_checker
  import jk_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int MAX_ERR = 8
) (
  input logic         clk,
  input logic         rst,
  jk_checker_if.slave bus
);

  // Halting is disabled when MAX_ERR is 0 or can never be reached by the counter.
  localparam bit               HALT_EN   = (MAX_ERR > 0) && ($clog2(MAX_ERR + 1) <= CNT_W);
  localparam logic [CNT_W-1:0] MAX_ERR_C = CNT_W'(MAX_ERR);

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] check_cnt_q, check_cnt_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_sticky_q, err_sticky_d;

  logic cmp_en, mismatch, model_load, model_step, halt_hit;
  logic exp_q;

  jk_ref_model u_ref (
    .clk     (clk),
    .rst     (rst),
    .load_i  (model_load),
    .step_i  (model_step),
    .jk_i    (bus.jk),
    .q_i     (bus.q),
    .exp_q_o (exp_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // clr outranks every state, including HALT.
  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = bus.en ? SYNC : IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (bus.en) state_d = SYNC;
        SYNC:  state_d = bus.en ? CHECK : IDLE;
        CHECK: begin
          if (!bus.en)       state_d = IDLE;
          else if (halt_hit) state_d = HALT;
        end
        HALT:  state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cmp_en     = (state_q == CHECK) && bus.en && !bus.clr;
    mismatch   = cmp_en && (bus.q != exp_q);
    model_load = ((state_q == SYNC) && bus.en && !bus.clr) || mismatch;
    model_step = cmp_en && !mismatch;
  end

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    check_cnt_d    = check_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    err_sticky_d   = err_sticky_q;
    err_pulse_d    = 1'b0;
    if (bus.clr) begin
      check_cnt_d    = '0;
      mismatch_cnt_d = '0;
      err_sticky_d   = 1'b0;
    end else if (cmp_en) begin
      if (!(&check_cnt_q)) check_cnt_d = check_cnt_q + CNT_W'(1);
      if (mismatch) begin
        if (!(&mismatch_cnt_q)) mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
        err_pulse_d  = 1'b1;
        err_sticky_d = 1'b1;
      end
    end
  end

  assign halt_hit = HALT_EN && mismatch && (mismatch_cnt_d == MAX_ERR_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      check_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      err_pulse_q    <= 1'b0;
      err_sticky_q   <= 1'b0;
    end else begin
      check_cnt_q    <= check_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      err_pulse_q    <= err_pulse_d;
      err_sticky_q   <= err_sticky_d;
    end
  end

  assign bus.exp_q        = exp_q;
  assign bus.err_pulse    = err_pulse_q;
  assign bus.err_sticky   = err_sticky_q;
  assign bus.check_cnt    = check_cnt_q;
  assign bus.mismatch_cnt = mismatch_cnt_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_jk_checker.sv
// Directed bench for jk_checker: three parameterisations driven from one sequence,
// each edge scored against a behavioural model through an expected-value queue.
module tb_jk_checker;

  typedef struct {
    int st;
    bit exp;
    bit pulse;
    bit sticky;
    int chk;
    int mis;
  } mdl_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jk_checker_if #(.CNT_W(16)) if_a ();
  jk_checker_if #(.CNT_W(16)) if_b ();
  jk_checker_if #(.CNT_W(4))  if_c ();

  jk_checker #(.CNT_W(16), .MAX_ERR(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  jk_checker #(.CNT_W(16), .MAX_ERR(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  jk_checker #(.CNT_W(4),  .MAX_ERR(0)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  int   n_assert = 0;
  int   n_fail   = 0;
  mdl_t sb_q[$];
  mdl_t m[3];
  int   cmax[3] = '{65535, 65535, 15};
  int   merr[3] = '{8, 3, 0};
  bit   en_v[3], clr_v[3], q_v[3];
  logic [1:0] jk_v[3];
  bit   ff;  // true state of the flop observed by dut_a

  function automatic bit ref_next(bit q, logic [1:0] jk);
    case (jk)
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, bit en, bit clr, logic [1:0] jk, bit q,
                                    int cm, int me);
    mdl_t n = s;
    n.pulse = 1'b0;
    if (clr) begin
      n.chk = 0; n.mis = 0; n.sticky = 1'b0;
      n.st  = en ? 1 : 0;
      return n;
    end
    case (s.st)
      0: if (en) n.st = 1;
      1: begin
        if (!en) n.st = 0;
        else begin n.exp = ref_next(q, jk); n.st = 2; end
      end
      2: begin
        if (!en) n.st = 0;
        else begin
          if (s.chk < cm) n.chk = s.chk + 1;
          if (q != s.exp) begin
            if (s.mis < cm) n.mis = s.mis + 1;
            n.pulse = 1'b1; n.sticky = 1'b1;
            n.exp = ref_next(q, jk);
            if (me != 0 && n.mis == me) n.st = 3;
          end else begin
            n.exp = ref_next(s.exp, jk);
          end
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  task automatic check(string tag, logic [31:0] obs, int expv);
    n_assert++;
    assert (obs === 32'(expv)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic compare_dut(int d, string tag);
    mdl_t e;
    logic [31:0] o_st, o_exp, o_p, o_s, o_c, o_m;
    e = sb_q.pop_front();
    case (d)
      0: begin
        o_st = 32'(if_a.state); o_exp = 32'(if_a.exp_q); o_p = 32'(if_a.err_pulse);
        o_s = 32'(if_a.err_sticky); o_c = 32'(if_a.check_cnt); o_m = 32'(if_a.mismatch_cnt);
      end
      1: begin
        o_st = 32'(if_b.state); o_exp = 32'(if_b.exp_q); o_p = 32'(if_b.err_pulse);
        o_s = 32'(if_b.err_sticky); o_c = 32'(if_b.check_cnt); o_m = 32'(if_b.mismatch_cnt);
      end
      default: begin
        o_st = 32'(if_c.state); o_exp = 32'(if_c.exp_q); o_p = 32'(if_c.err_pulse);
        o_s = 32'(if_c.err_sticky); o_c = 32'(if_c.check_cnt); o_m = 32'(if_c.mismatch_cnt);
      end
    endcase
    check({tag, ".state"},        o_st,  e.st);
    check({tag, ".exp_q"},        o_exp, int'(e.exp));
    check({tag, ".err_pulse"},    o_p,   int'(e.pulse));
    check({tag, ".err_sticky"},   o_s,   int'(e.sticky));
    check({tag, ".check_cnt"},    o_c,   e.chk);
    check({tag, ".mismatch_cnt"}, o_m,   e.mis);
  endtask

  task automatic drive_all();
    if_a.en = en_v[0]; if_a.clr = clr_v[0]; if_a.jk = jk_v[0]; if_a.q = q_v[0];
    if_b.en = en_v[1]; if_b.clr = clr_v[1]; if_b.jk = jk_v[1]; if_b.q = q_v[1];
    if_c.en = en_v[2]; if_c.clr = clr_v[2]; if_c.jk = jk_v[2]; if_c.q = q_v[2];
  endtask

  task automatic reset_models();
    for (int i = 0; i < 3; i++) m[i] = '{0, 1'b0, 1'b0, 1'b0, 0, 0};
  endtask

  // One clock edge: drive DUT d, advance all models, score DUT d.
  task automatic cyc(int d, bit en, bit clr, logic [1:0] jk, bit q, string tag);
    en_v[d] = en; clr_v[d] = clr; jk_v[d] = jk; q_v[d] = q;
    drive_all();
    for (int i = 0; i < 3; i++)
      m[i] = mdl_step(m[i], en_v[i], clr_v[i], jk_v[i], q_v[i], cmax[i], merr[i]);
    sb_q.push_back(m[d]);
    @(posedge clk);
    #1;
    compare_dut(d, tag);
  endtask

  task automatic a_step(bit en, logic [1:0] jk, bit fault, string tag);
    cyc(0, en, 1'b0, jk, ff ^ fault, tag);
    ff = ref_next(ff, jk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      en_v[i] = 1'b0; clr_v[i] = 1'b0; jk_v[i] = 2'b00; q_v[i] = 1'b0;
    end
    drive_all();
    ff  = 1'b0;
    rst = 1'b1;
    reset_models();
    repeat (2) @(posedge clk);
    #1;
    sb_q.push_back(m[0]);
    compare_dut(0, "reset");
    rst = 1'b0;

    // Normal operation with a well-behaved flop.
    a_step(1'b1, 2'b00, 1'b0, "s1_e0");
    check("s1_sync", 32'(if_a.state), 1);
    a_step(1'b1, 2'b10, 1'b0, "s1_e1");
    check("s1_check", 32'(if_a.state), 2);
    check("s1_nocmp_in_sync", 32'(if_a.check_cnt), 0);
    a_step(1'b1, 2'b11, 1'b0, "s1_e2");
    a_step(1'b1, 2'b11, 1'b0, "s1_e3");
    a_step(1'b1, 2'b01, 1'b0, "s1_e4");
    a_step(1'b1, 2'b00, 1'b0, "s1_e5");
    check("s1_check_cnt", 32'(if_a.check_cnt), 4);
    check("s1_mismatch_cnt", 32'(if_a.mismatch_cnt), 0);
    check("s1_sticky", 32'(if_a.err_sticky), 0);

    // Single corrupted observation; J=1,K=0 on that edge so the true flop and the
    // resynced model agree afterwards.
    a_step(1'b1, 2'b11, 1'b0, "s2_pre");
    a_step(1'b1, 2'b10, 1'b1, "s2_fault");
    check("s2_pulse_hi", 32'(if_a.err_pulse), 1);
    check("s2_mis1", 32'(if_a.mismatch_cnt), 1);
    check("s2_sticky", 32'(if_a.err_sticky), 1);
    a_step(1'b1, 2'b00, 1'b0, "s2_post0");
    check("s2_pulse_lo", 32'(if_a.err_pulse), 0);
    a_step(1'b1, 2'b11, 1'b0, "s2_post1");
    a_step(1'b1, 2'b01, 1'b0, "s2_post2");
    a_step(1'b1, 2'b11, 1'b0, "s2_post3");
    a_step(1'b1, 2'b00, 1'b0, "s2_post4");
    check("s2_no_more_err", 32'(if_a.mismatch_cnt), 1);
    check("s2_sticky_held", 32'(if_a.err_sticky), 1);
    check("s2_check_cnt", 32'(if_a.check_cnt), 11);

    // Enable drop for three cycles.
    for (int i = 0; i < 3; i++) begin
      a_step(1'b0, 2'b01, 1'b0, "s6_off");
      check("s6_idle", 32'(if_a.state), 0);
      check("s6_cnt_held", 32'(if_a.check_cnt), 11);
    end
    a_step(1'b1, 2'b10, 1'b0, "s6_on0");
    check("s6_sync", 32'(if_a.state), 1);
    check("s6_no_cmp", 32'(if_a.check_cnt), 11);
    a_step(1'b1, 2'b11, 1'b0, "s6_on1");
    a_step(1'b1, 2'b00, 1'b0, "s6_on2");
    check("s6_resumed", 32'(if_a.check_cnt), 12);

    // Asynchronous reset between edges while checking.
    a_step(1'b1, 2'b11, 1'b0, "s5_pre");
    #2;
    rst = 1'b1;
    #1;
    reset_models();
    sb_q.push_back(m[0]);
    compare_dut(0, "s5_async");
    check("s5_b_state", 32'(if_b.state), 0);
    #2;
    rst = 1'b0;
    a_step(1'b1, 2'b10, 1'b0, "s5_r0");
    a_step(1'b1, 2'b11, 1'b0, "s5_r1");
    check("s5_no_early_cmp", 32'(if_a.check_cnt), 0);
    a_step(1'b1, 2'b00, 1'b0, "s5_r2");
    check("s5_first_cmp", 32'(if_a.check_cnt), 1);
    a_step(1'b0, 2'b00, 1'b0, "s5_park");

    // Halt after three mismatches (q stuck at 0 under toggle).
    for (int i = 0; i < 5; i++) cyc(1, 1'b1, 1'b0, 2'b11, 1'b0, "s3_run");
    check("s3_halt", 32'(if_b.state), 3);
    check("s3_mis", 32'(if_b.mismatch_cnt), 3);
    for (int i = 0; i < 3; i++) cyc(1, 1'b1, 1'b0, 2'b11, 1'b0, "s3_frozen");
    check("s3_chk_frozen", 32'(if_b.check_cnt), 3);
    check("s3_mis_frozen", 32'(if_b.mismatch_cnt), 3);
    cyc(1, 1'b1, 1'b1, 2'b11, 1'b0, "s3_clr");
    check("s3_clr_sync", 32'(if_b.state), 1);
    check("s3_clr_mis", 32'(if_b.mismatch_cnt), 0);
    cyc(1, 1'b0, 1'b0, 2'b00, 1'b0, "s3_park");

    // Saturation with a 4-bit counter and halting disabled.
    for (int i = 0; i < 22; i++) cyc(2, 1'b1, 1'b0, 2'b11, 1'b0, "s4_run");
    check("s4_mis_sat", 32'(if_c.mismatch_cnt), 15);
    check("s4_chk_sat", 32'(if_c.check_cnt), 15);
    check("s4_still_pulsing", 32'(if_c.err_pulse), 1);
    check("s4_no_halt", 32'(if_c.state), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_checker.md
JK_CHECKER -- requirements
Module: jk_checker

Interface
REQ-001 Parameter CNT_W, 16, width of the check and mismatch counters.
REQ-002 Parameter MAX_ERR, 8, mismatch count that moves the block to HALT; 0 means never halt.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port en  input  1  checking enable.
REQ-006 Port clr  input  1  synchronous clear of counters and sticky error.
REQ-007 Port jk  input  2  observed flip-flop stimulus; jk[1]=J, jk[0]=K.
REQ-008 Port q  input  1  observed flip-flop output.
REQ-009 Port exp_q  output  1  model's expected q for the current sample.
REQ-010 Port err_pulse  output  1  one-cycle flag for a mismatch.
REQ-011 Port err_sticky  output  1  set on the first mismatch, held until clr or rst.
REQ-012 Port check_cnt  output  CNT_W  number of compared samples.
REQ-013 Port mismatch_cnt  output  CNT_W  number of mismatching samples.
REQ-014 Port state  output  2  current FSM state (IDLE=0, SYNC=1, CHECK=2, HALT=3).

Function
REQ-015 Sampling: jk and q SHALL be sampled on every rising clk edge; q at edge n reflects jk sampled at edge n-1.
REQ-016 JK decoding SHALL be: 00 hold, 01 clear to 0, 10 set to 1, 11 toggle.
REQ-017 IDLE: no compares. Exit to SYNC on the first edge with en=1.
REQ-018 SYNC lasts exactly one cycle with no compare.
REQ-019 In SYNC, the model SHALL load next(q, jk) and then enter CHECK.
REQ-020 CHECK, each edge: compare q with exp_q; increment check_cnt; then model <= next(exp_q, jk).
REQ-021 On a CHECK mismatch, the block SHALL:
  - increment mismatch_cnt;
  - assert err_pulse on the following cycle only, giving 1-cycle latency;
  - set err_sticky;
  - resync the model to next(q, jk) so one fault gives one error.
REQ-022 When mismatch_cnt reaches MAX_ERR (MAX_ERR!=0), the next state SHALL be HALT.
REQ-023 HALT: no compares; counters frozen. Leave only via clr or rst.
REQ-024 en=0 in SYNC or CHECK SHALL move the block to IDLE on the next edge, with counters held.
REQ-025 Re-enabling SHALL always pass through SYNC.
REQ-026 Counters SHALL saturate at all-ones and never wrap.
REQ-027 clr=1 SHALL zero both counters and err_sticky and deassert err_pulse.
REQ-028 After clr, the next state SHALL be SYNC if en=1, else IDLE; clr takes priority over any compare on the same edge.
REQ-029 A mismatch on the edge that saturates mismatch_cnt SHALL still pulse err_pulse.

Reset
REQ-030 rst SHALL immediately force state=IDLE, exp_q=0, err_pulse=0, err_sticky=0, check_cnt=0 and mismatch_cnt=0, independent of clk.
REQ-031 Deasserting rst mid-operation SHALL resume in IDLE.
REQ-032 After rst deasserts, the first compare SHALL occur no earlier than two en=1 edges later.

Structure
REQ-033 Package jk_pkg SHALL hold:
  - enum jk_op_e (HOLD, CLR, SET, TGL);
  - enum chk_state_e;
  - function jk_next(q, jk).
REQ-034 Sub-module jk_ref_model SHALL hold the 1-bit model register with load (SYNC or resync) and step inputs; the FSM and counters live in jk_checker.

Verification
REQ-035 Scenario 1, normal operation:
  - stimulus: rst, then en=1, jk sequence 10,11,11,01,00 with a correct q;
  - required: state goes IDLE->SYNC->CHECK; check_cnt=4; mismatch_cnt=0; err_sticky=0.
REQ-036 Scenario 2, single fault:
  - stimulus: in CHECK, force q inverted for one cycle;
  - required: err_pulse high for exactly 1 cycle, one cycle after the sample; mismatch_cnt=1; err_sticky=1; no further errors (resync).
REQ-037 Scenario 3, halt:
  - stimulus: MAX_ERR=3 with q stuck at 0 under jk=11;
  - required: HALT after the 3rd mismatch; counters frozen; clr returns to SYNC with counters at 0.
REQ-038 Scenario 4, saturation:
  - stimulus: CNT_W=4, MAX_ERR=0, 20 mismatching samples;
  - required: mismatch_cnt=15, still pulsing.
REQ-039 Scenario 5, asynchronous reset:
  - stimulus: rst asserted between clock edges while in CHECK;
  - required: all outputs at reset values before the next edge; state=IDLE.
REQ-040 Scenario 6, enable drop:
  - stimulus: en dropped for 3 cycles, then restored;
  - required: IDLE for those cycles, then SYNC, with no compare on the first re-enabled edge.
